// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning matrix keypad controller.
// Drives one column low at a time, samples the synchronised rows at the end
// of each dwell, debounces press and release, and hands each confirmed key
// to the consumer over a valid/ready pair with an overrun pulse on drops.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4,
    parameter int HEX_MAP      = 1,
    localparam int CW          = ($clog2(ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_drive,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            overrun
);

    localparam int RW = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1;
    localparam int CLW = ($clog2(COLS) > 0) ? $clog2(COLS) : 1;
    localparam int DW = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;

    // The hex-style mapping only makes sense for the classic 4x4 pad.
    if (HEX_MAP != 0 && (ROWS != 4 || COLS != 4)) begin : gHexMapCheck
        $error("keypad_scanner: HEX_MAP=1 requires ROWS=4 and COLS=4");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ROWS-1:0] rowMeta_q, rowSync_q;
    logic [DW-1:0]   divCnt_q, divCnt_d;
    logic [CLW-1:0]  colIdx_q, colIdx_d;
    logic [RW-1:0]   rowIdx_q, rowIdx_d;
    logic [7:0]      matchCnt_q, matchCnt_d;
    logic [7:0]      relCnt_q, relCnt_d;
    logic [COLS-1:0] colDrive_q, colDrive_d;
    logic [CW-1:0]   keyCode_q, keyCode_d;
    logic            keyValid_q, keyValid_d;
    logic            overrun_q, overrun_d;

    logic            sample;
    logic            anyLow;
    logic [RW-1:0]   lowRow;
    logic            capturedLow;
    logic [CLW-1:0]  colNext;
    logic            emit;
    logic [CW-1:0]   newCode;
    logic            matchDone;
    logic            releaseDone;

    // Two-flop synchroniser for the asynchronous row lines; idles released (high).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rowMeta_q <= '1;
            rowSync_q <= '1;
        end else begin
            rowMeta_q <= row_in;
            rowSync_q <= rowMeta_q;
        end
    end

    assign sample      = (divCnt_q == DW'(SCAN_DIV - 1));
    assign colNext     = (colIdx_q == CLW'(COLS - 1)) ? '0 : colIdx_q + 1'b1;
    assign capturedLow = ~rowSync_q[rowIdx_q];
    assign matchDone   = ({1'b0, matchCnt_q} + 9'd1) == 9'(DEBOUNCE_CNT);
    assign releaseDone = ({1'b0, relCnt_q} + 9'd1) == 9'(DEBOUNCE_CNT);

    // Free-running dwell counter; the sample point is its last count.
    always_comb begin
        divCnt_d = sample ? '0 : divCnt_q + 1'b1;
    end

    // Lowest-index low row wins when several rows are pressed in one column.
    always_comb begin
        anyLow = 1'b0;
        lowRow = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rowSync_q[i]) begin
                anyLow = 1'b1;
                lowRow = RW'(i);
            end
        end
    end

    // Encode the captured row/column into the delivered key code.
    always_comb begin
        int unsigned lin;
        lin = int'(rowIdx_q) * COLS + int'(colIdx_q);
        if (HEX_MAP != 0) begin
            newCode = CW'((lin + 1) % 16);
        end else begin
            newCode = CW'(lin);
        end
    end

    // Scan / debounce / held sequencing, evaluated only at sample points.
    always_comb begin
        state_d    = state_q;
        colIdx_d   = colIdx_q;
        rowIdx_d   = rowIdx_q;
        matchCnt_d = matchCnt_q;
        relCnt_d   = relCnt_q;
        emit       = 1'b0;
        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (anyLow) begin
                        rowIdx_d   = lowRow;
                        matchCnt_d = '0;
                        state_d    = DEBOUNCE;
                    end else begin
                        colIdx_d = colNext;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (capturedLow) begin
                        if (matchDone) begin
                            emit       = 1'b1;
                            matchCnt_d = '0;
                            relCnt_d   = '0;
                            state_d    = HELD;
                        end else begin
                            matchCnt_d = matchCnt_q + 1'b1;
                        end
                    end else begin
                        matchCnt_d = '0;
                        colIdx_d   = colNext;
                        state_d    = SCAN;
                    end
                end
            end
            HELD: begin
                if (sample) begin
                    if (!capturedLow) begin
                        if (releaseDone) begin
                            relCnt_d = '0;
                            colIdx_d = colNext;
                            state_d  = SCAN;
                        end else begin
                            relCnt_d = relCnt_q + 1'b1;
                        end
                    end else begin
                        relCnt_d = '0;
                    end
                end
            end
            default: begin
                state_d    = SCAN;
                colIdx_d   = '0;
                matchCnt_d = '0;
                relCnt_d   = '0;
            end
        endcase
    end

    // Column drive follows the next column index so the pins are registered.
    always_comb begin
        colDrive_d = ~(COLS'(1) << colIdx_d);
    end

    // Output handshake: load on a free slot, otherwise keep the old key and flag overrun.
    always_comb begin
        keyCode_d  = keyCode_q;
        keyValid_d = keyValid_q;
        overrun_d  = 1'b0;
        if (emit) begin
            if (!keyValid_q || key_ready) begin
                keyCode_d  = newCode;
                keyValid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (keyValid_q && key_ready) begin
            keyValid_d = 1'b0;
        end
    end

    // State and datapath registers, all returning to idle-scan values on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SCAN;
            divCnt_q   <= '0;
            colIdx_q   <= '0;
            rowIdx_q   <= '0;
            matchCnt_q <= '0;
            relCnt_q   <= '0;
            colDrive_q <= ~(COLS'(1));
            keyCode_q  <= '0;
            keyValid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            colIdx_q   <= colIdx_d;
            rowIdx_q   <= rowIdx_d;
            matchCnt_q <= matchCnt_d;
            relCnt_q   <= relCnt_d;
            colDrive_q <= colDrive_d;
            keyCode_q  <= keyCode_d;
            keyValid_q <= keyValid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign col_drive = colDrive_q;
    assign key_code  = keyCode_q;
    assign key_valid = keyValid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a hex-mapped and a linear-mapped
// instance share one modelled 4x4 keypad and are checked against
// hand-computed codes and cycle-exact scan timing.
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        key_ready;
    logic [15:0] pressedMap;
    logic [3:0]  rowIn, rowIn0;
    logic [3:0]  colDrive, colDrive0;
    logic [3:0]  keyCode, keyCode0;
    logic        keyValid, keyValid0;
    logic        overrun, overrun0;

    int checks = 0;
    int failures = 0;
    int cyc;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CNT(3), .HEX_MAP(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .row_in(rowIn), .col_drive(colDrive),
        .key_code(keyCode), .key_valid(keyValid), .key_ready(key_ready), .overrun(overrun)
    );

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CNT(3), .HEX_MAP(0)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .row_in(rowIn0), .col_drive(colDrive0),
        .key_code(keyCode0), .key_valid(keyValid0), .key_ready(key_ready), .overrun(overrun0)
    );

    always #5 clock = ~clock;

    // Counts rising edges since reset release; edges with cyc%4==0 are sample points.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rowIn  = '1;
        rowIn0 = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressedMap[r*4+c] && !colDrive[c])  rowIn[r]  = 1'b0;
                if (pressedMap[r*4+c] && !colDrive0[c]) rowIn0[r] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for a fresh drive of column c.
    task automatic waitColDriven(input int c);
        int n = 0;
        while (colDrive[c] == 1'b0 && n < 100) begin @(negedge clock); n++; end
        while (colDrive[c] == 1'b1 && n < 200) begin @(negedge clock); n++; end
        checkOutput("colDriven", 32'(colDrive[c]), 32'd0);
    endtask

    // Presses the keys in mask with key_ready high, checks the delivered codes, releases.
    task automatic applyStimulus(input logic [15:0] mask, input logic [3:0] expCode,
                                 input logic [3:0] expCode0, input string tag);
        int n = 0;
        int extra = 0;
        pressedMap = mask;
        while (!keyValid && n < 300) begin @(negedge clock); n++; end
        checkOutput({tag, "_valid"}, 32'(keyValid), 32'd1);
        checkOutput({tag, "_code"}, 32'(keyCode), 32'(expCode));
        checkOutput({tag, "_valid0"}, 32'(keyValid0), 32'd1);
        checkOutput({tag, "_code0"}, 32'(keyCode0), 32'(expCode0));
        pressedMap = '0;
        repeat (40) begin @(negedge clock); if (keyValid) extra++; end
        checkOutput({tag, "_extra"}, 32'(extra), 32'd0);
    endtask

    initial begin
        logic [3:0] expCol;
        int pulses;
        int k;
        int s1;

        reset_n = 1'b1;
        key_ready = 1'b0;
        pressedMap = '0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstCol", 32'(colDrive), 32'h0e);
        checkOutput("rstValid", 32'(keyValid), 32'd0);
        checkOutput("rstOverrun", 32'(overrun), 32'd0);

        // Column stepping, four clocks per column.
        @(negedge clock) reset_n = 1'b1;
        expCol = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clock);
            expCol = {expCol[2:0], expCol[3]};
            checkOutput("scanStep", 32'(colDrive), 32'(expCol));
        end

        // Asynchronous reset mid-scan.
        repeat (5) @(negedge clock);
        checkOutput("midScanCol", 32'(colDrive), 32'h0d);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midRstCol", 32'(colDrive), 32'h0e);
        checkOutput("midRstValid", 32'(keyValid), 32'd0);

        // Clean press row0/col0: first low sample at edge 4, key_valid after edge 16.
        pressedMap = 16'h0001;
        @(negedge clock) reset_n = 1'b1;
        repeat (15) @(negedge clock);
        checkOutput("latPre", 32'(keyValid), 32'd0);
        @(negedge clock);
        checkOutput("latValid", 32'(keyValid), 32'd1);
        checkOutput("latCode", 32'(keyCode), 32'h1);
        checkOutput("latCode0", 32'(keyCode0), 32'h0);
        key_ready = 1'b1;
        @(negedge clock);
        checkOutput("consumed", 32'(keyValid), 32'd0);
        checkOutput("codeHeld", 32'(keyCode), 32'h1);
        pulses = 0;
        repeat (20) begin @(negedge clock); if (keyValid) pulses++; end
        checkOutput("noRepeat", 32'(pulses), 32'd0);
        pressedMap = '0;
        repeat (30) @(negedge clock);

        // Code mapping on both instances.
        applyStimulus(16'h8000, 4'h0, 4'hf, "r3c3");
        applyStimulus(16'h0040, 4'h7, 4'h6, "r1c2");

        // Bounce: one low sample in column 1, then released.
        pressedMap = 16'h0200;
        waitColDriven(1);
        repeat (4) @(negedge clock);
        checkOutput("bounceHalt", 32'(colDrive), 32'h0d);
        pressedMap = '0;
        repeat (4) @(negedge clock);
        checkOutput("bounceResume", 32'(colDrive), 32'h0b);
        pulses = 0;
        repeat (40) begin @(negedge clock); if (keyValid) pulses++; end
        checkOutput("bounceNoKey", 32'(pulses), 32'd0);
        applyStimulus(16'h0200, 4'ha, 4'h9, "stable");

        // Long hold of row2/col0 with a release bounce, then exact release timing.
        pressedMap = 16'h0100;
        pulses = 0;
        repeat (200) begin @(negedge clock); if (keyValid) pulses++; end
        checkOutput("holdPulses", 32'(pulses), 32'd1);
        checkOutput("holdCode", 32'(keyCode), 32'h9);
        k = cyc;
        pressedMap = '0;
        s1 = ((k + 3 + 3) / 4) * 4;
        repeat (s1 + 1 - k) @(negedge clock);
        pressedMap = 16'h0100;
        repeat (16) @(negedge clock);
        checkOutput("holdBounce", 32'(colDrive), 32'h0e);
        k = cyc;
        pressedMap = '0;
        s1 = ((k + 3 + 3) / 4) * 4;
        repeat (s1 + 7 - k) @(negedge clock);
        checkOutput("relPre", 32'(colDrive), 32'h0e);
        @(negedge clock);
        checkOutput("relResume", 32'(colDrive), 32'h0d);
        repeat (30) @(negedge clock);

        // Backpressure: second key is dropped with a single overrun pulse.
        key_ready = 1'b0;
        pressedMap = 16'h0001;
        k = 0;
        while (!keyValid && k < 300) begin @(negedge clock); k++; end
        checkOutput("bpFirst", 32'(keyCode), 32'h1);
        pressedMap = '0;
        repeat (40) @(negedge clock);
        pressedMap = 16'h0002;
        pulses = 0;
        repeat (150) begin @(negedge clock); if (overrun) pulses++; end
        checkOutput("bpOverrun", 32'(pulses), 32'd1);
        checkOutput("bpCodeKept", 32'(keyCode), 32'h1);
        checkOutput("bpValid", 32'(keyValid), 32'd1);
        pressedMap = '0;
        repeat (40) @(negedge clock);
        key_ready = 1'b1;
        @(negedge clock);
        checkOutput("bpClear", 32'(keyValid), 32'd0);
        repeat (10) @(negedge clock);

        // Two rows low in column 1: row 0 wins.
        applyStimulus(16'h0202, 4'h2, 4'h1, "twoRows");

        // Reset while debouncing row1/col3: nothing emitted afterwards.
        pressedMap = 16'h0080;
        waitColDriven(3);
        repeat (4) @(negedge clock);
        checkOutput("dbHalt", 32'(colDrive), 32'h07);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("dbRstCol", 32'(colDrive), 32'h0e);
        pressedMap = '0;
        @(negedge clock) reset_n = 1'b1;
        pulses = 0;
        repeat (60) begin @(negedge clock); if (keyValid) pulses++; end
        checkOutput("dbRstNoKey", 32'(pulses), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
